// File: rtl/xnor_popcount_acc.sv
// XNOR/popcount accumulator: counts matching bits of in_a and in_b over BEATS accepted beats,
// then holds the total and a threshold decision until the consumer takes them.
module xnor_popcount_acc #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned BEATS  = 4,
    parameter int unsigned THRESH = WIDTH * BEATS / 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  clr,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [WIDTH-1:0]                      in_a,
    input  logic [WIDTH-1:0]                      in_b,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [$clog2(WIDTH*BEATS+1)-1:0]      out_count,
    output logic                                  out_bit
);
    localparam int unsigned CW = $clog2(WIDTH * BEATS + 1);
    localparam int unsigned BW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] THRESH_C = CW'(THRESH);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    typedef enum logic {StAcc, StHold} state_t;

    state_t            state;
    logic [CW-1:0]     acc;
    logic [BW-1:0]     beat_cnt;
    logic [WIDTH-1:0]  match;
    logic [CW-1:0]     pc;
    logic [CW-1:0]     sum;

    assign match = ~(in_a ^ in_b);

    always_comb begin
        pc = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            pc = pc + CW'(match[i]);
        end
    end

    // Cannot overflow: the group total is bounded by WIDTH*BEATS, which CW is sized for.
    assign sum = acc + pc;

    assign in_ready = (state == StAcc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StAcc;
            acc       <= '0;
            beat_cnt  <= '0;
            out_valid <= 1'b0;
            out_count <= '0;
            out_bit   <= 1'b0;
        end else begin
            unique case (state)
                StAcc: begin
                    // clr takes priority over any beat offered in the same cycle.
                    if (clr) begin
                        acc      <= '0;
                        beat_cnt <= '0;
                    end else if (in_valid) begin
                        if (beat_cnt == LAST_BEAT) begin
                            out_count <= sum;
                            out_bit   <= (sum >= THRESH_C);
                            out_valid <= 1'b1;
                            acc       <= '0;
                            beat_cnt  <= '0;
                            state     <= StHold;
                        end else begin
                            acc      <= sum;
                            beat_cnt <= beat_cnt + BW'(1);
                        end
                    end
                end
                StHold: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= StAcc;
                    end
                end
                default: state <= StAcc;
            endcase
        end
    end

endmodule
